if_fetch: RTL and testbench

//  Instruction-fetch stage: owns the PC, issues requests on a req/ack instruction bus and presents pc/inst to if_id.
//  - Raises stallreq to ctrl while no instruction is available; ctrl answers with stall=6'b000011 and if_id inserts a bubble.
//  - Handles branch redirects from id, including the delay slot.
//  - Handles exception flushes from ctrl (new_pc).

---
 rtl/if_fetch_pkg.sv | 28 ++
 rtl/if_fetch.sv | 168 ++++++++++++++++
 tb/tb_if_fetch.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [INST_W-1:0]      ZERO_WORD    = 32'h0000_0000;

    // IDLE : one cycle after reset with fetch disabled
    // FETCH: request outstanding on the instruction bus
    // HOLD : word captured while the pipeline was stalled, bus idle
    // DRAIN: flushed while a request was in flight; wait for its ack, drop data
    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_HOLD  = 2'd2,
        IF_DRAIN = 2'd3
    } if_state_e;

    // Sequential fetch address; wraps naturally at the top of the address space.
    function automatic logic [INST_ADDR_W-1:0] next_word(input logic [INST_ADDR_W-1:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, runs a req/ack instruction bus, presents pc/inst to if_id.
// Latency: inst is valid in the ack cycle (0-wait memory sustains one instruction per cycle).
// Backpressure: stall[0] freezes the PC; a word arriving while stalled is buffered (HOLD).
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   stall[5:0], flush,new_pc from ctrl (only stall[0] is used here)
//   branch_flag_i, branch_target_address_i   taken branch from id (delay slot honoured)
//   ibus_req/addr/ack/rdata  instruction bus; req holds with a stable address until ack
//   pc, inst, ce             to if_id
//   stallreq                 to ctrl: no instruction available this cycle
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] new_pc,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_address_i,
    output logic                   ibus_req,
    output logic [INST_ADDR_W-1:0] ibus_addr,
    input  logic                   ibus_ack,
    input  logic [INST_W-1:0]      ibus_rdata,
    output logic [INST_ADDR_W-1:0] pc,
    output logic [INST_W-1:0]      inst,
    output logic                   ce,
    output logic                   stallreq
);

    if_state_e              r_state,     w_state_nxt;
    logic [INST_ADDR_W-1:0] r_pc,        w_pc_nxt;
    logic [INST_W-1:0]      r_buf,       w_buf_nxt;
    logic                   r_buf_valid, w_buf_valid_nxt;
    logic                   r_br_pend,   w_br_pend_nxt;
    logic [INST_ADDR_W-1:0] r_br_target, w_br_target_nxt;
    logic [INST_ADDR_W-1:0] r_redir_pc,  w_redir_pc_nxt;
    logic                   r_ce,        w_ce_nxt;

    logic                   w_avail;
    logic                   w_consume;
    logic [INST_ADDR_W-1:0] w_next_pc;
    logic                   w_unused;

    // Upper stall bits belong to later pipeline stages.
    assign w_unused = ^stall[5:1];

    assign w_avail   = r_ce & ((ibus_ack & (r_state == IF_FETCH)) | r_buf_valid);
    assign w_consume = w_avail & ~stall[0] & ~flush;

    // A branch arriving in the same cycle the delay slot is consumed redirects immediately.
    assign w_next_pc = branch_flag_i ? branch_target_address_i :
                       r_br_pend     ? r_br_target             :
                                       next_word(r_pc);

    assign ibus_req  = (r_state == IF_FETCH) | (r_state == IF_DRAIN);
    // In DRAIN the PC is untouched, so the bus keeps the in-flight address.
    assign ibus_addr = r_pc;
    assign pc        = r_pc;
    assign inst      = r_buf_valid ? r_buf : (r_ce ? ibus_rdata : ZERO_WORD);
    assign ce        = r_ce;
    assign stallreq  = r_ce & ~w_avail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IF_IDLE;
            r_pc        <= RESET_PC;
            r_buf       <= ZERO_WORD;
            r_buf_valid <= 1'b0;
            r_br_pend   <= 1'b0;
            r_br_target <= RESET_PC;
            r_redir_pc  <= RESET_PC;
            r_ce        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_buf       <= w_buf_nxt;
            r_buf_valid <= w_buf_valid_nxt;
            r_br_pend   <= w_br_pend_nxt;
            r_br_target <= w_br_target_nxt;
            r_redir_pc  <= w_redir_pc_nxt;
            r_ce        <= w_ce_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_buf_nxt       = r_buf;
        w_buf_valid_nxt = r_buf_valid;
        w_br_pend_nxt   = r_br_pend;
        w_br_target_nxt = r_br_target;
        w_redir_pc_nxt  = r_redir_pc;
        w_ce_nxt        = r_ce;

        // Branch capture ignores stall; a same-cycle consume below overrides it.
        if (branch_flag_i && !flush) begin
            w_br_pend_nxt   = 1'b1;
            w_br_target_nxt = branch_target_address_i;
        end

        case (r_state)
            IF_IDLE: begin
                w_ce_nxt    = 1'b1;
                w_state_nxt = IF_FETCH;
                if (flush) begin
                    w_pc_nxt = new_pc;
                end
            end

            IF_FETCH: begin
                if (flush) begin
                    w_br_pend_nxt   = 1'b0;
                    w_buf_valid_nxt = 1'b0;
                    if (!ibus_ack) begin
                        // Request cannot be aborted: park the target until the ack.
                        w_redir_pc_nxt = new_pc;
                        w_state_nxt    = IF_DRAIN;
                    end else begin
                        w_pc_nxt = new_pc;
                    end
                end else if (ibus_ack) begin
                    if (w_consume) begin
                        w_pc_nxt      = w_next_pc;
                        w_br_pend_nxt = 1'b0;
                    end else begin
                        w_buf_nxt       = ibus_rdata;
                        w_buf_valid_nxt = 1'b1;
                        w_state_nxt     = IF_HOLD;
                    end
                end
            end

            IF_HOLD: begin
                if (flush) begin
                    w_pc_nxt        = new_pc;
                    w_br_pend_nxt   = 1'b0;
                    w_buf_valid_nxt = 1'b0;
                    w_state_nxt     = IF_FETCH;
                end else if (w_consume) begin
                    w_pc_nxt        = w_next_pc;
                    w_br_pend_nxt   = 1'b0;
                    w_buf_valid_nxt = 1'b0;
                    w_state_nxt     = IF_FETCH;
                end
            end

            IF_DRAIN: begin
                if (flush) begin
                    w_br_pend_nxt  = 1'b0;
                    w_redir_pc_nxt = new_pc;
                end
                if (ibus_ack) begin
                    w_pc_nxt    = flush ? new_pc : r_redir_pc;
                    w_state_nxt = IF_FETCH;
                end
            end

            default: begin
                w_state_nxt = IF_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch against a transaction-level model of the fetch stream.
// Latency: n/a.
// Backpressure: random bus wait states, stalls, flushes and branches.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_address_i = '0;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack = 1'b0;
    logic [31:0] ibus_rdata = '0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ce;
    logic        stallreq;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .ibus_req                (ibus_req),
        .ibus_addr               (ibus_addr),
        .ibus_ack                (ibus_ack),
        .ibus_rdata              (ibus_rdata),
        .pc                      (pc),
        .inst                    (inst),
        .ce                      (ce),
        .stallreq                (stallreq)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] pick_addr();
        if ($urandom_range(15, 0) == 0) return 32'hFFFF_FFFC;
        return 32'($urandom_range(255, 0)) << 2;
    endfunction

    // Model: expected address of the next delivered instruction, pending branch,
    // whether a delivered-but-unconsumed word is held, whether a flushed
    // request is still in flight, and whether fetching is enabled.
    logic [31:0] m_pc, m_tgt;
    bit          m_pend, m_hold, m_drain, m_ce;

    // Bus slave and stimulus knobs
    bit          s_busy;
    int          s_left;
    int          s_min_wait = 0, s_max_wait = 0;
    int          p_stall = 0, p_flush = 0, p_br = 0;
    bit          b_out;
    logic [31:0] b_addr;

    task automatic model_reset();
        m_pc = RESET_PC_DEF; m_tgt = '0;
        m_pend = 0; m_hold = 0; m_drain = 0; m_ce = 0;
        s_busy = 0; s_left = 0; b_out = 0; b_addr = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b0; ibus_ack = 1'b0; stall = '0; flush = 1'b0; branch_flag_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_req",      32'(ibus_req), 32'd0);
        chk_eq("rst_ce",       32'(ce),       32'd0);
        chk_eq("rst_stallreq", 32'(stallreq), 32'd0);
        chk_eq("rst_pc",       pc,            RESET_PC_DEF);
        chk_eq("rst_addr",     ibus_addr,     RESET_PC_DEF);
        chk_eq("rst_inst",     inst,          32'd0);
        model_reset();
        rst = 1'b1;
    endtask

    task automatic step(input bit force_flush);
        bit s0, fl, br, req_m, avail_m, cons;
        @(negedge clk);
        if (ibus_req && !s_busy) begin
            s_busy = 1;
            s_left = int'($urandom_range(s_max_wait, s_min_wait));
        end
        ibus_ack   = ibus_req && s_busy && (s_left == 0);
        ibus_rdata = ibus_ack ? mem_word(ibus_addr) : $urandom();
        s0 = $urandom_range(99, 0) < p_stall;
        stall = s0 ? 6'b000011 : 6'b000000;
        fl = m_ce && (force_flush || ($urandom_range(99, 0) < p_flush));
        flush  = fl;
        new_pc = pick_addr();
        br = m_ce && ($urandom_range(99, 0) < p_br);
        branch_flag_i = br;
        branch_target_address_i = pick_addr();
        #1;

        req_m   = m_ce && !m_hold;
        avail_m = m_ce && (m_hold || (req_m && !m_drain && ibus_ack));

        chk_eq("ce",       32'(ce),       32'(m_ce));
        chk_eq("req",      32'(ibus_req), 32'(req_m));
        chk_eq("stallreq", 32'(stallreq), 32'(m_ce && !avail_m));
        if (req_m && !m_drain) chk_eq("addr", ibus_addr, m_pc);
        if (b_out)             chk_eq("addr_hold", ibus_addr, b_addr);
        if (avail_m) begin
            chk_eq("pc",   pc,   m_pc);
            chk_eq("inst", inst, mem_word(m_pc));
        end

        cons = avail_m && !s0 && !fl;
        if (fl) begin
            m_pc = new_pc; m_pend = 0; m_hold = 0;
            m_drain = req_m && !ibus_ack;
        end else if (cons) begin
            m_pc   = br ? branch_target_address_i : (m_pend ? m_tgt : m_pc + 32'd4);
            m_pend = 0; m_hold = 0;
        end else begin
            if (br) begin m_pend = 1; m_tgt = branch_target_address_i; end
            if (avail_m) m_hold = 1;
            if (m_drain && ibus_ack) m_drain = 0;
        end
        m_ce = 1;

        b_out  = ibus_req && !ibus_ack;
        b_addr = ibus_addr;
        if (ibus_ack) s_busy = 0;
        else if (s_busy && s_left > 0) s_left--;
    endtask

    initial begin
        model_reset();
        apply_reset();

        // 0-wait memory, free-running sequential fetch
        s_min_wait = 0; s_max_wait = 0;
        repeat (8) step(0);

        // fixed 2-wait memory
        s_min_wait = 2; s_max_wait = 2;
        repeat (12) step(0);

        // random wait states with stalls, flushes and branches
        s_min_wait = 0; s_max_wait = 3;
        p_stall = 30; p_flush = 8; p_br = 15;
        repeat (3000) step(0);

        // heavy stall with 0-wait memory exercises HOLD
        s_max_wait = 0; p_stall = 60; p_flush = 4; p_br = 20;
        repeat (500) step(0);

        // async reset while draining a flushed request
        p_stall = 0; p_flush = 0; p_br = 0;
        apply_reset();
        s_min_wait = 4; s_max_wait = 4;
        repeat (2) step(0);
        step(1);
        step(0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk_eq("mid_rst_req",      32'(ibus_req), 32'd0);
        chk_eq("mid_rst_ce",       32'(ce),       32'd0);
        chk_eq("mid_rst_stallreq", 32'(stallreq), 32'd0);
        chk_eq("mid_rst_pc",       pc,            RESET_PC_DEF);
        chk_eq("mid_rst_addr",     ibus_addr,     RESET_PC_DEF);
        chk_eq("mid_rst_inst",     inst,          32'd0);
        ibus_ack = 1'b0; flush = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        s_min_wait = 0; s_max_wait = 0;
        repeat (6) step(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
